instruction_fetch_unit: RTL and testbench

Front-end fetch stage of the SigmaCore pipeline. It sits directly upstream of the instruction memory. It owns the program counter and drives the IMEM read address. It absorbs the IMEM's one-cycle registered read latency, and presents {instruction, PC, valid} to decode. Decode can stall it, and execute can redirect it for branches and jumps. A one-entry skid register ensures no fetched word is lost or duplicated across stalls.

---
 rtl/instruction_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//    Front-end fetch stage. Owns the PC, drives the IMEM read address, absorbs
//    the one-cycle registered IMEM latency and presents {instr, pc, valid} to
//    decode. A one-entry skid register catches the response that lands while
//    decode is stalling, so no word is lost or duplicated.
//
//    Optional build macro: MISALIGN_TRAP_EN
//       defined   : redirect to a target with target[1:0] != 0 raises a sticky
//                   fetch_fault_out and parks the unit in FAULT until rst.
//       undefined : target[1:0] is forced to 0 on load, fetch_fault_out is 0.
//
//    Ports:
//       clk, rst                 core clock, async active-high reset
//       stall_in                 decode cannot accept; hold output stage
//       redirect_valid_in/target execute-requested PC change (beats stall)
//       imem_addr_out            IMEM read address (= pc_q)
//       imem_rdata_in            IMEM data, one cycle after the address
//       instr_valid_out/instr_out/instr_pc_out   decode-facing output stage
//       fetch_fault_out          sticky misaligned-redirect fault
//
//    state | meaning
//    RUN   | normal fetch
//    FAULT | fetch halted after misaligned redirect; only rst exits
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        redirect_valid_in,
   input  logic [31:0] redirect_target_in,
   output logic [31:0] imem_addr_out,
   input  logic [31:0] imem_rdata_in,
   output logic        instr_valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc_out,
   output logic        fetch_fault_out
);

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic        inflight_valid_q;
   logic [31:0] inflight_pc_q;
   logic        skid_valid_q;
   logic [31:0] skid_instr_q;
   logic [31:0] skid_pc_q;
   logic        out_valid_q;
   logic [31:0] out_instr_q;
   logic [31:0] out_pc_q;
   logic        fault_q;

   logic        misaligned;
   logic        trap_hit;
   logic [31:0] load_target;
   logic        do_redirect;
   logic        do_flush;
   logic        do_capture;
   logic        do_issue;

   assign misaligned  = |redirect_target_in[1:0];
   assign trap_hit    = TRAP_EN && misaligned;
   // Without the trap the low bits are dropped; with it a misaligned target
   // goes straight to FAULT, so loading it as-is is harmless.
   assign load_target = TRAP_EN ? redirect_target_in
                                : {redirect_target_in[31:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == RUN && redirect_valid_in && trap_hit) state_d = FAULT;
   end

   always_comb begin
      do_redirect = 1'b0;
      do_flush    = 1'b0;
      do_capture  = 1'b0;
      do_issue    = 1'b0;
      case (state_q)
         RUN: begin
            if (redirect_valid_in) begin
               do_redirect = 1'b1;
               do_flush    = 1'b1;
            end else if (stall_in) begin
               do_capture = inflight_valid_q;
            end else begin
               do_issue = 1'b1;
            end
         end
         default: do_flush = 1'b1;   // FAULT: keep pipeline empty
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q             <= RESET_PC;
         inflight_valid_q <= 1'b0;
         inflight_pc_q    <= 32'h0;
         skid_valid_q     <= 1'b0;
         skid_instr_q     <= NOP_INSTR;
         skid_pc_q        <= 32'h0;
         out_valid_q      <= 1'b0;
         out_instr_q      <= NOP_INSTR;
         out_pc_q         <= 32'h0;
         fault_q          <= 1'b0;
      end else begin
         if (do_redirect)   pc_q <= load_target;
         else if (do_issue) pc_q <= pc_q + 32'd4;

         inflight_valid_q <= do_issue;
         if (do_issue) inflight_pc_q <= pc_q;

         if (do_flush) begin
            skid_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
         end else if (do_capture) begin
            // Stall never issues, so the skid can only ever fill once.
            skid_valid_q <= 1'b1;
            skid_instr_q <= imem_rdata_in;
            skid_pc_q    <= inflight_pc_q;
         end else if (do_issue) begin
            if (skid_valid_q) begin
               out_valid_q  <= 1'b1;
               out_instr_q  <= skid_instr_q;
               out_pc_q     <= skid_pc_q;
               skid_valid_q <= 1'b0;
            end else begin
               out_valid_q <= inflight_valid_q;
               out_instr_q <= inflight_valid_q ? imem_rdata_in : NOP_INSTR;
               out_pc_q    <= inflight_pc_q;
            end
         end

         if (do_redirect && trap_hit) fault_q <= 1'b1;
      end
   end

   assign imem_addr_out   = pc_q;
   assign instr_valid_out = out_valid_q;
   assign instr_out       = out_instr_q;
   assign instr_pc_out    = out_pc_q;
   assign fetch_fault_out = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redir;
   logic [31:0] tgt;
   logic [31:0] addr0, rdata0, instr0, pc0;
   logic        valid0, fault0;
   logic [31:0] addr1, rdata1, instr1, pc1;
   logic        valid1, fault1;

   int tests = 0;
   int fails = 0;

   instruction_fetch_unit dut0 (
      .clk(clk), .rst(rst), .stall_in(stall), .redirect_valid_in(redir),
      .redirect_target_in(tgt), .imem_addr_out(addr0), .imem_rdata_in(rdata0),
      .instr_valid_out(valid0), .instr_out(instr0), .instr_pc_out(pc0),
      .fetch_fault_out(fault0));

   instruction_fetch_unit #(.RESET_PC(RPC1)) dut1 (
      .clk(clk), .rst(rst), .stall_in(stall), .redirect_valid_in(redir),
      .redirect_target_in(tgt), .imem_addr_out(addr1), .imem_rdata_in(rdata1),
      .instr_valid_out(valid1), .instr_out(instr1), .instr_pc_out(pc1),
      .fetch_fault_out(fault1));

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0050_0093;
         32'h4:   return 32'h00A0_0113;
         32'h8:   return 32'h0020_81B3;
         32'hC:   return NOP;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   // Registered-read IMEM models
   initial begin rdata0 = 32'h0; rdata1 = 32'h0; end
   always @(posedge clk) begin
      rdata0 <= imem_word(addr0);
      rdata1 <= imem_word(addr1);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] tgt;
      logic        v;
      logic [31:0] pc;
      logic        ca;
      logic [31:0] addr;
      logic        c1;
      logic [31:0] pc1;
      logic        flt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic s, input logic d,
                               input logic [31:0] t, input logic v,
                               input logic [31:0] p, input logic ca,
                               input logic [31:0] a, input logic c1,
                               input logic [31:0] p1, input logic f);
      vec_t x;
      x.rst = r; x.stall = s; x.redir = d; x.tgt = t; x.v = v; x.pc = p;
      x.ca = ca; x.addr = a; x.c1 = c1; x.pc1 = p1; x.flt = f;
      return x;
   endfunction

   // Reference-model state for random phase
   logic [31:0] m_addr, exp_next;
   logic        faulted, hold_prev, pv;
   logic [1:0]  clean;
   int          blank;
   logic [31:0] ppc, pinstr;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'h0;
      @(negedge clk);
      chk("rst.valid", {31'b0, valid0}, 32'd0);
      chk("rst.instr", instr0, NOP);
      chk("rst.pc", pc0, 32'h0);
      chk("rst.fault", {31'b0, fault0}, 32'd0);
      chk("rst.addr0", addr0, 32'h0);
      chk("rst.addr1", addr1, RPC1);
      chk("rst.fault1", {31'b0, fault1}, 32'd0);
      rst = 1'b0;
      m_addr = 32'h0; exp_next = 32'h0; faulted = 1'b0; hold_prev = 1'b0;
      clean = 2'b00; blank = 0; pv = 1'b0; ppc = 32'h0; pinstr = NOP;
   endtask

   initial begin
      logic s, d;
      logic [31:0] t;

      rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'h0;

      // Segment A: reset release, stall with skid, RESET_PC wrap on dut1
      tbl.push_back(mk(0,0,0,0, 0,32'h0, 1,32'h0,  0,0,            0));
      tbl.push_back(mk(0,0,0,0, 0,32'h0, 1,32'h4,  0,0,            0));
      tbl.push_back(mk(0,0,0,0, 1,32'h0, 1,32'h8,  1,32'hFFFF_FFF8, 0));
      tbl.push_back(mk(0,1,0,0, 1,32'h4, 1,32'hC,  1,32'hFFFF_FFFC, 0));
      tbl.push_back(mk(0,1,0,0, 1,32'h4, 1,32'hC,  1,32'hFFFF_FFFC, 0));
      tbl.push_back(mk(0,1,0,0, 1,32'h4, 1,32'hC,  1,32'hFFFF_FFFC, 0));
      tbl.push_back(mk(0,0,0,0, 1,32'h4, 1,32'hC,  1,32'hFFFF_FFFC, 0));
      tbl.push_back(mk(0,0,0,0, 1,32'h8, 1,32'h10, 1,32'h0,        0));
      tbl.push_back(mk(0,0,0,0, 1,32'hC, 1,32'h14, 1,32'h4,        0));
      tbl.push_back(mk(0,0,0,0, 1,32'h10,1,32'h18, 1,32'h8,        0));
      tbl.push_back(mk(1,0,0,0, 1,32'h14,1,32'h1C, 1,32'hC,        0));
      // Segment B: redirect, redirect+stall with full skid, misaligned target
      tbl.push_back(mk(0,0,0,0,       0,32'h0, 1,32'h0,  0,0,0));
      tbl.push_back(mk(0,0,0,0,       0,32'h0, 1,32'h4,  0,0,0));
      tbl.push_back(mk(0,0,0,0,       1,32'h0, 1,32'h8,  0,0,0));
      tbl.push_back(mk(0,0,0,0,       1,32'h4, 1,32'hC,  0,0,0));
      tbl.push_back(mk(0,0,1,32'h20,  1,32'h8, 1,32'h10, 0,0,0));
      tbl.push_back(mk(0,0,0,0,       0,32'h0, 1,32'h20, 0,0,0));
      tbl.push_back(mk(0,0,0,0,       0,32'h0, 1,32'h24, 0,0,0));
      tbl.push_back(mk(0,0,0,0,       1,32'h20,1,32'h28, 0,0,0));
      tbl.push_back(mk(0,1,0,0,       1,32'h24,1,32'h2C, 0,0,0));
      tbl.push_back(mk(0,1,1,32'h40,  1,32'h24,1,32'h2C, 0,0,0));
      tbl.push_back(mk(0,0,0,0,       0,32'h0, 1,32'h40, 0,0,0));
      tbl.push_back(mk(0,0,0,0,       0,32'h0, 1,32'h44, 0,0,0));
      tbl.push_back(mk(0,0,0,0,       1,32'h40,1,32'h48, 0,0,0));
      tbl.push_back(mk(0,0,1,32'h22,  1,32'h44,1,32'h4C, 0,0,0));
      tbl.push_back(mk(0,0,0,0, 0,    32'h0, !TRAP,32'h20, 0,0,TRAP));
      tbl.push_back(mk(0,0,0,0, 0,    32'h0, !TRAP,32'h24, 0,0,TRAP));
      tbl.push_back(mk(0,0,0,0, !TRAP,32'h20,!TRAP,32'h28, 0,0,TRAP));
      tbl.push_back(mk(0,0,0,0, !TRAP,32'h24,!TRAP,32'h2C, 0,0,TRAP));

      @(negedge clk);
      @(negedge clk);
      foreach (tbl[i]) begin
         chk($sformatf("v%0d.valid", i), {31'b0, valid0}, {31'b0, tbl[i].v});
         if (tbl[i].v) begin
            chk($sformatf("v%0d.pc", i), pc0, tbl[i].pc);
            chk($sformatf("v%0d.instr", i), instr0, imem_word(tbl[i].pc));
         end else begin
            chk($sformatf("v%0d.nop", i), instr0, NOP);
         end
         if (tbl[i].ca) chk($sformatf("v%0d.addr", i), addr0, tbl[i].addr);
         if (tbl[i].c1) begin
            chk($sformatf("v%0d.valid1", i), {31'b0, valid1}, 32'd1);
            chk($sformatf("v%0d.pc1", i), pc1, tbl[i].pc1);
            chk($sformatf("v%0d.instr1", i), instr1, imem_word(tbl[i].pc1));
         end
         chk($sformatf("v%0d.fault", i), {31'b0, fault0}, {31'b0, tbl[i].flt});
         rst = tbl[i].rst; stall = tbl[i].stall;
         redir = tbl[i].redir; tgt = tbl[i].tgt;
         @(negedge clk);
      end

      // Random phase against a transaction-level model: PCs consumed in order,
      // redirect -> two bubbles, two clean edges -> valid, stall -> hold.
      for (int chunk = 0; chunk < 5; chunk++) begin
         do_reset();
         for (int cyc = 0; cyc < 600; cyc++) begin
            if (faulted) begin
               chk("rnd.fault_valid", {31'b0, valid0}, 32'd0);
               chk("rnd.fault_flag", {31'b0, fault0}, 32'd1);
            end else begin
               chk("rnd.fault0", {31'b0, fault0}, 32'd0);
               chk("rnd.addr", addr0, m_addr);
               if (blank > 0) begin
                  chk("rnd.bubble", {31'b0, valid0}, 32'd0);
                  blank--;
               end else if (clean == 2'b11) begin
                  chk("rnd.stream", {31'b0, valid0}, 32'd1);
               end
               if (hold_prev) begin
                  chk("rnd.hold_v", {31'b0, valid0}, {31'b0, pv});
                  if (pv) begin
                     chk("rnd.hold_pc", pc0, ppc);
                     chk("rnd.hold_instr", instr0, pinstr);
                  end
               end
            end
            if (valid0) chk("rnd.instr", instr0, imem_word(pc0));
            else        chk("rnd.nop", instr0, NOP);
            pv = valid0; ppc = pc0; pinstr = instr0;

            s = ($urandom_range(0, 99) < 30);
            d = ($urandom_range(0, 99) < 8);
            t = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            stall = s; redir = d; tgt = t;

            if (!faulted) begin
               if (valid0 && !s) begin
                  chk("rnd.order", pc0, exp_next);
                  exp_next = exp_next + 32'd4;
               end
               if (d) begin
                  if (TRAP && t[1:0] != 2'b00) begin
                     faulted = 1'b1;
                  end else begin
                     exp_next = {t[31:2], 2'b00};
                     m_addr   = exp_next;
                  end
                  blank = 2; clean = {clean[0], 1'b0}; hold_prev = 1'b0;
               end else if (s) begin
                  clean = {clean[0], 1'b0}; hold_prev = 1'b1;
               end else begin
                  m_addr = m_addr + 32'd4;
                  clean = {clean[0], 1'b1}; hold_prev = 1'b0;
               end
            end
            @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
